// File: rtl/mem_stage.sv
// Memory/writeback stage: forwards ALU results or performs one memory access, then a one-cycle writeback.
// Optional MEM_TIMEOUT_EN: abandon a memory access after 255 unacknowledged cycles and pulse O_mem_err.
module mem_stage (
    input  logic        I_clk,
    input  logic        I_reset,
    input  logic        I_enable,
    input  logic [15:0] I_alu_out,
    input  logic        I_write_rD,
    input  logic        I_write_pc,
    input  logic [1:0]  I_memory_mode,
    input  logic [2:0]  I_rD_sel,
    input  logic [15:0] I_store_data,
    input  logic        I_mem_ack,
    input  logic [15:0] I_mem_rdata,
    output logic        O_mem_req,
    output logic        O_mem_we,
    output logic [15:0] O_mem_addr,
    output logic [15:0] O_mem_wdata,
    output logic        O_reg_we,
    output logic [2:0]  O_reg_sel,
    output logic [15:0] O_reg_data,
    output logic        O_pc_we,
    output logic [15:0] O_pc,
    output logic        O_busy,
    output logic        O_mem_err
);

    localparam logic [1:0] MEM_NOP   = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM,
        S_WB
    } state_t;

    state_t state;
    state_t next_state;

    logic        start_access;
    logic        timeout_hit;

    logic        d_mem_req;
    logic        d_mem_we;
    logic [15:0] d_mem_addr;
    logic [15:0] d_mem_wdata;
    logic        d_reg_we;
    logic [2:0]  d_reg_sel;
    logic [15:0] d_reg_data;
    logic        d_pc_we;
    logic [15:0] d_pc;
    logic        d_busy;
    logic        d_mem_err;

    // Reserved mode 2'b11 is deliberately treated as a plain register/PC forward.
    assign start_access = (I_memory_mode == MEM_READ) || (I_memory_mode == MEM_WRITE);

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Counter is zero on the first MEM cycle, so 254 marks the 255th cycle.
    assign timeout_hit = (tmo_cnt == 8'd254);

    always_ff @(posedge I_clk) begin
        if (I_reset || state != S_MEM) begin
            tmo_cnt <= 8'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state       <= S_IDLE;
            O_mem_req   <= 1'b0;
            O_mem_we    <= 1'b0;
            O_mem_addr  <= 16'h0000;
            O_mem_wdata <= 16'h0000;
            O_reg_we    <= 1'b0;
            O_reg_sel   <= 3'd0;
            O_reg_data  <= 16'h0000;
            O_pc_we     <= 1'b0;
            O_pc        <= 16'h0000;
            O_busy      <= 1'b0;
        end else begin
            state       <= next_state;
            O_mem_req   <= d_mem_req;
            O_mem_we    <= d_mem_we;
            O_mem_addr  <= d_mem_addr;
            O_mem_wdata <= d_mem_wdata;
            O_reg_we    <= d_reg_we;
            O_reg_sel   <= d_reg_sel;
            O_reg_data  <= d_reg_data;
            O_pc_we     <= d_pc_we;
            O_pc        <= d_pc;
            O_busy      <= d_busy;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            O_mem_err <= 1'b0;
        end else begin
            O_mem_err <= d_mem_err;
        end
    end
`else
    assign O_mem_err = 1'b0;
`endif

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (I_enable) begin
                    next_state = start_access ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                if (I_mem_ack) begin
                    next_state = S_WB;
                end else if (timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            S_WB: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Next values of the output registers; write pulses default low, everything else holds.
    always_comb begin
        d_mem_req   = O_mem_req;
        d_mem_we    = O_mem_we;
        d_mem_addr  = O_mem_addr;
        d_mem_wdata = O_mem_wdata;
        d_reg_we    = 1'b0;
        d_reg_sel   = O_reg_sel;
        d_reg_data  = O_reg_data;
        d_pc_we     = 1'b0;
        d_pc        = O_pc;
        d_busy      = O_busy;
        d_mem_err   = 1'b0;
        case (state)
            S_IDLE: begin
                d_busy = 1'b0;
                if (I_enable) begin
                    d_busy    = 1'b1;
                    d_reg_sel = I_rD_sel;
                    if (start_access) begin
                        d_mem_req   = 1'b1;
                        d_mem_we    = (I_memory_mode == MEM_WRITE);
                        d_mem_addr  = I_alu_out;
                        d_mem_wdata = I_store_data;
                    end else begin
                        d_reg_we   = I_write_rD;
                        d_pc_we    = I_write_pc;
                        d_reg_data = I_alu_out;
                        d_pc       = I_alu_out;
                    end
                end
            end
            S_MEM: begin
                if (I_mem_ack) begin
                    d_mem_req = 1'b0;
                    if (!O_mem_we) begin
                        d_reg_we   = 1'b1;
                        d_reg_data = I_mem_rdata;
                    end
                end else if (timeout_hit) begin
                    d_mem_req = 1'b0;
                    d_busy    = 1'b0;
                    d_mem_err = 1'b1;
                end
            end
            S_WB: begin
                d_busy = 1'b0;
            end
            default: begin
                d_busy = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 SHALL provide ports, one per line (name, direction, width, meaning):
- I_clk  in  1  clock, all state on rising edge
- I_reset  in  1  synchronous active-high reset
- I_enable  in  1  ALU result valid this cycle
- I_alu_out  in  16  ALU result: data, memory address or PC target
- I_write_rD  in  1  ALU requests register write
- I_write_pc  in  1  ALU requests PC write
- I_memory_mode  in  2  MEM_NOP/MEM_READ/MEM_WRITE per mem_acc.vh
- I_rD_sel  in  3  destination register index
- I_store_data  in  16  data for MEM_WRITE
- I_mem_ack  in  1  memory completes access
- I_mem_rdata  in  16  read data, valid with I_mem_ack
- O_mem_req  out  1  memory access request
- O_mem_we  out  1  1=write, 0=read, valid while O_mem_req
- O_mem_addr  out  16  access address
- O_mem_wdata  out  16  write data
- O_reg_we  out  1  register-file write pulse
- O_reg_sel  out  3  register index
- O_reg_data  out  16  register write data
- O_pc_we  out  1  PC write pulse
- O_pc  out  16  new PC value
- O_busy  out  1  stage occupied; upstream holds
- O_mem_err  out  1  access timeout pulse (REQ-019)

Function
REQ-003 SHALL have states IDLE, MEM, WB; all outputs registered.
REQ-004 SHALL sample all I_* operands only when I_enable=1 in IDLE; I_enable in MEM/WB ignored.
REQ-005 SHALL, for MEM_NOP or reserved code 2'b11, go IDLE->WB; O_reg_we=I_write_rD, O_pc_we=I_write_pc, O_reg_data=O_pc=I_alu_out in WB (enable cycle N -> pulse cycle N+1).
REQ-006 SHALL, for MEM_READ/MEM_WRITE, go IDLE->MEM, O_mem_addr=I_alu_out, O_mem_we=(mode==MEM_WRITE), O_mem_wdata=I_store_data; O_mem_req=1 every MEM cycle.
REQ-007 SHALL hold O_mem_req and addr/data/we stable until I_mem_ack=1 is sampled while O_mem_req=1; then -> WB, O_mem_req=0 next cycle.
REQ-008 SHALL, on read completion, latch I_mem_rdata into O_reg_data; WB pulses O_reg_we=1 regardless of I_write_rD.
REQ-009 SHALL, on write completion, emit WB with O_reg_we=0 and O_pc_we=0.
REQ-010 SHALL remain in WB exactly one cycle, then IDLE; O_reg_we/O_pc_we high only in WB.
REQ-011 SHALL assert O_busy=1 in MEM and WB, 0 in IDLE.
REQ-012 SHALL ignore I_mem_ack in IDLE and WB.
REQ-013 SHALL pulse both O_reg_we and O_pc_we if both requested under MEM_NOP.
REQ-014 SHALL make minimum read latency 2 cycles (enable N, ack N+1, O_reg_we N+2).

Reset
REQ-015 SHALL on I_reset=1 force IDLE and clear every output to 0 at next edge.
REQ-016 SHALL on reset mid-MEM drop O_mem_req next edge, suppress pending writeback; later ack ignored.
REQ-017 SHALL give I_reset priority over I_enable and I_mem_ack.

Configuration
REQ-018 SHALL, with MEM_TIMEOUT_EN undefined, wait in MEM indefinitely; O_mem_err tied 0.
REQ-019 SHALL, with MEM_TIMEOUT_EN defined, count MEM cycles in 8-bit counter cleared on MEM entry; on 255th cycle without ack: O_mem_req=0, O_mem_err 1-cycle pulse, IDLE, no reg/PC write.

Verification
REQ-020 ADD result: enable, I_alu_out=16'h1234, I_write_rD=1, I_rD_sel=3, NOP -> next cycle O_reg_we=1, O_reg_sel=3, O_reg_data=16'h1234.
REQ-021 READ addr 16'h0040, ack after 3 req cycles with rdata 16'hBEEF -> req high 3 cycles, O_reg_data=16'hBEEF pulse cycle after ack.
REQ-022 WRITE addr 16'h0010, data 16'h00AA, ack immediately -> O_mem_we=1, one req cycle, no O_reg_we, O_busy 2 cycles.
REQ-023 JMP: I_write_pc=1, I_alu_out=16'h0105 -> O_pc_we pulse, O_pc=16'h0105; second I_enable during busy ignored.
REQ-024 Reset in MEM cycle 2, ack next cycle -> no O_reg_we, O_mem_req 0; with MEM_TIMEOUT_EN, no ack 255 cycles -> O_mem_err pulse, IDLE.
